block_gen: RTL

BLOCK_GEN -- requirements
Module: block_gen

---
 rtl/block_gen.sv | 64 ++++++
 1 files changed

// File: rtl/block_gen.sv
// block_gen: LFSR piece generator with cur/nxt preview queue; BLOCK_GEN_NO_REPEAT_EN rejects back-to-back identical pieces
module block_gen #(
  parameter int          NUM_BLOCKS   = 5,
  parameter logic [15:0] SEED_DEFAULT = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        seed_load,
  input  logic [15:0] seed,
  input  logic        req,
  output logic [2:0]  block_num,
  output logic        block_valid,
  output logic [2:0]  next_num,
  output logic        ready
);
  typedef enum logic {FILL, RUN} state_t;
  state_t      state;
  logic [15:0] lfsr;
  logic        nxt_vld;
  logic [2:0]  cand;
  logic        acc;
  logic        load;
  assign cand  = lfsr[2:0];
  assign ready = (state == RUN) && block_valid && nxt_vld;
  // a queue slot is free exactly when nxt is empty; block_valid picks cur vs nxt
  assign load  = acc && !nxt_vld;
`ifdef BLOCK_GEN_NO_REPEAT_EN
  logic [2:0] last_q;
  assign acc = (int'(cand) < NUM_BLOCKS) && (cand != last_q);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) last_q <= 3'b111;
    else if (seed_load) last_q <= 3'b111;
    else if (load) last_q <= cand;
`else
  assign acc = int'(cand) < NUM_BLOCKS;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      lfsr        <= SEED_DEFAULT;
      state       <= FILL;
      block_num   <= '0;
      next_num    <= '0;
      block_valid <= 1'b0;
      nxt_vld     <= 1'b0;
    end else if (seed_load) begin
      lfsr        <= (seed == 16'h0000) ? SEED_DEFAULT : seed;
      state       <= FILL;
      block_valid <= 1'b0;
      nxt_vld     <= 1'b0;
    end else begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      if (ready && req) begin
        block_num <= next_num;
        nxt_vld   <= 1'b0;
      end else if (load && !block_valid) begin
        block_num   <= cand;
        block_valid <= 1'b1;
      end else if (load) begin
        next_num <= cand;
        nxt_vld  <= 1'b1;
        state    <= RUN;
      end
    end
endmodule
